// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared IFU types and constants: bus width, FSM states, AXI response codes.
`ifndef FU_TO_DU_BUS_WD
`define FU_TO_DU_BUS_WD 64
`endif

package ysyx_25020037_ifu_pkg;

  localparam int FU_TO_DU_BUS_WD = `FU_TO_DU_BUS_WD;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25020037_ifu_if.sv
// AXI4-Lite read channel (AR/R only) between the IFU and instruction memory.
interface ysyx_25020037_ifu_if;

  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;

  modport master (
    output ifu_araddr,
    output ifu_arvalid,
    input  ifu_arready,
    input  ifu_rvalid,
    output ifu_rready,
    input  ifu_rdata,
    input  ifu_rresp
  );

  modport slave (
    input  ifu_araddr,
    input  ifu_arvalid,
    output ifu_arready,
    output ifu_rvalid,
    input  ifu_rready,
    output ifu_rdata,
    output ifu_rresp
  );

endinterface

// File: rtl/ysyx_25020037_ifu_pc.sv
// PC register with deferred-redirect tracking; next-pc priority is
// reset > redirect (direct or pending) > pc+4 on accept > hold.
module ysyx_25020037_ifu_pc #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_dnpc,
  input  logic        load_redir,
  input  logic        inc_pc,
  input  logic        defer_redir,
  input  logic        clear_pend,
  input  logic [31:0] exu_dnpc,
  output logic [31:0] pc,
  output logic        redir_pend
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] redir_pc_reg, redir_pc_next;
  logic        pend_reg, pend_next;

  always_comb begin
    pc_next = pc_reg;
    if (load_dnpc) begin
      pc_next = exu_dnpc;
    end else if (load_redir) begin
      pc_next = redir_pc_reg;
    end else if (inc_pc) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // A redirect arriving while a pend is outstanding simply overwrites it.
  always_comb begin
    pend_next     = pend_reg;
    redir_pc_next = redir_pc_reg;
    if (defer_redir) begin
      pend_next     = 1'b1;
      redir_pc_next = exu_dnpc;
    end else if (clear_pend) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      redir_pc_reg <= 32'h0;
      pend_reg     <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      redir_pc_reg <= redir_pc_next;
      pend_reg     <= pend_next;
    end
  end

  assign pc         = pc_reg;
  assign redir_pend = pend_reg;

endmodule

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one AXI-Lite read per instruction, {pc,inst} to IDU.
// Define YSYX_25020037_IFU_MISALIGN_CHK_EN to fault misaligned PCs without a bus read.
module ysyx_25020037_ifu
  import ysyx_25020037_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       idu_ready,
  output logic                       ifu_valid,
  output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
  input  logic                       exu_dnpc_valid,
  input  logic [31:0]                exu_dnpc,
  output logic                       ifu_fault,
  ysyx_25020037_ifu_if.master        axi
);

  ifu_state_e  state_reg, state_next;
  logic [31:0] inst_reg, inst_next;
  logic        fault_reg, fault_next;

  logic [31:0] pc;
  logic        redir_pend;
  logic        load_dnpc;
  logic        load_redir;
  logic        inc_pc;
  logic        defer_redir;
  logic        clear_pend;
  logic        misaligned;

`ifdef YSYX_25020037_IFU_MISALIGN_CHK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  ysyx_25020037_ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_dnpc   (load_dnpc),
    .load_redir  (load_redir),
    .inc_pc      (inc_pc),
    .defer_redir (defer_redir),
    .clear_pend  (clear_pend),
    .exu_dnpc    (exu_dnpc),
    .pc          (pc),
    .redir_pend  (redir_pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      inst_reg  <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    inst_next   = inst_reg;
    fault_next  = fault_reg;
    load_dnpc   = 1'b0;
    load_redir  = 1'b0;
    inc_pc      = 1'b0;
    defer_redir = 1'b0;
    clear_pend  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_AR;
        load_dnpc  = exu_dnpc_valid;
      end
      S_AR: begin
        if (misaligned) begin
          // No request is on the bus, so a redirect can be taken immediately.
          load_dnpc = exu_dnpc_valid;
          if (!exu_dnpc_valid) begin
            state_next = S_OUT;
            inst_next  = 32'h0;
            fault_next = 1'b1;
          end
        end else begin
          // arvalid/araddr must stay stable, so redirects are only remembered.
          defer_redir = exu_dnpc_valid;
          if (axi.ifu_arready) begin
            state_next = S_R;
          end
        end
      end
      S_R: begin
        if (axi.ifu_rvalid) begin
          clear_pend = 1'b1;
          inst_next  = axi.ifu_rdata;
          fault_next = (axi.ifu_rresp != RESP_OKAY);
          if (exu_dnpc_valid || redir_pend) begin
            state_next = S_AR;
            load_dnpc  = exu_dnpc_valid;
            load_redir = !exu_dnpc_valid;
          end else begin
            state_next = S_OUT;
          end
        end else begin
          defer_redir = exu_dnpc_valid;
        end
      end
      S_OUT: begin
        if (exu_dnpc_valid) begin
          load_dnpc  = 1'b1;
          state_next = S_AR;
        end else if (idu_ready) begin
          inc_pc     = 1'b1;
          state_next = S_AR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign axi.ifu_araddr  = pc;
  assign axi.ifu_arvalid = (state_reg == S_AR) && !misaligned;
  assign axi.ifu_rready  = (state_reg == S_R);

  assign ifu_valid    = (state_reg == S_OUT);
  assign fu_to_du_bus = ifu_valid ? {pc, inst_reg} : '0;
  assign ifu_fault    = ifu_valid && fault_reg;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the IFU: handshake, stalls, redirects, faults, wrap, async reset.
`timescale 1ns/1ps
module tb_ysyx_25020037_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idu_ready = 1'b0;
  logic        ifu_valid;
  logic [63:0] fu_to_du_bus;
  logic        exu_dnpc_valid = 1'b0;
  logic [31:0] exu_dnpc = 32'h0;
  logic        ifu_fault;
  logic [3:0]  st;
  logic [63:0] exp_bus;

  int vectors = 0;
  int miscompares = 0;

  ysyx_25020037_ifu_if axi ();

  ysyx_25020037_ifu #(
    .RESET_PC (32'h3000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .idu_ready      (idu_ready),
    .ifu_valid      (ifu_valid),
    .fu_to_du_bus   (fu_to_du_bus),
    .exu_dnpc_valid (exu_dnpc_valid),
    .exu_dnpc       (exu_dnpc),
    .ifu_fault      (ifu_fault),
    .axi            (axi)
  );

  always #5 clk = ~clk;

  // {ifu_valid, arvalid, rready, ifu_fault}
  assign st = {ifu_valid, axi.ifu_arvalid, axi.ifu_rready, ifu_fault};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    axi.ifu_arready = 1'b1;
    axi.ifu_rvalid  = 1'b1;
    axi.ifu_rdata   = 32'h0000_0013;
    axi.ifu_rresp   = 2'b00;
    rst = 1'b1;
    repeat (2) tick();
    vectors++; if (st !== 4'b0000) begin miscompares++; $display("FAIL reset_status got=%b exp=%b", st, 4'b0000); end
    vectors++; if (fu_to_du_bus !== 64'h0) begin miscompares++; $display("FAIL reset_bus got=%h exp=%h", fu_to_du_bus, 64'h0); end
    rst = 1'b0;
    vectors++; if (st !== 4'b0000) begin miscompares++; $display("FAIL idle_status got=%b exp=%b", st, 4'b0000); end
    tick();
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL first_ar got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0000) begin miscompares++; $display("FAIL first_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0000); end
    tick();
    vectors++; if (st !== 4'b0010) begin miscompares++; $display("FAIL first_r got=%b exp=%b", st, 4'b0010); end
    tick();
    exp_bus = {32'h3000_0000, 32'h0000_0013};
    vectors++; if (st !== 4'b1000) begin miscompares++; $display("FAIL first_valid got=%b exp=%b", st, 4'b1000); end
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL first_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL second_ar got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0004) begin miscompares++; $display("FAIL second_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0004); end
  endtask

  task automatic test_stall;
    axi.ifu_rdata = 32'h0010_0093;
    repeat (2) tick();
    exp_bus = {32'h3000_0004, 32'h0010_0093};
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL stall_bus0 got=%h exp=%h", fu_to_du_bus, exp_bus); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (st !== 4'b1000) begin miscompares++; $display("FAIL stall_status[%0d] got=%b exp=%b", i, st, 4'b1000); end
      vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL stall_bus[%0d] got=%h exp=%h", i, fu_to_du_bus, exp_bus); end
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    vectors++; if (axi.ifu_araddr !== 32'h3000_0008) begin miscompares++; $display("FAIL stall_next_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0008); end
  endtask

  task automatic test_redirect_in_r;
    axi.ifu_rvalid = 1'b0;
    tick();
    vectors++; if (st !== 4'b0010) begin miscompares++; $display("FAIL rdir_r got=%b exp=%b", st, 4'b0010); end
    exu_dnpc_valid = 1'b1;
    exu_dnpc = 32'h3000_0100;
    tick();
    exu_dnpc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (st !== 4'b0010) begin miscompares++; $display("FAIL rdir_wait[%0d] got=%b exp=%b", i, st, 4'b0010); end
      tick();
    end
    axi.ifu_rvalid = 1'b1;
    axi.ifu_rdata  = 32'hdead_beef;
    tick();
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL rdir_drop got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0100) begin miscompares++; $display("FAIL rdir_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0100); end
    axi.ifu_rdata = 32'h0000_0013;
    repeat (2) tick();
    exp_bus = {32'h3000_0100, 32'h0000_0013};
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL rdir_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
  endtask

  task automatic test_redirect_accept;
    idu_ready = 1'b1;
    exu_dnpc_valid = 1'b1;
    exu_dnpc = 32'h3000_0200;
    tick();
    idu_ready = 1'b0;
    exu_dnpc_valid = 1'b0;
    vectors++; if (axi.ifu_araddr !== 32'h3000_0200) begin miscompares++; $display("FAIL racc_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0200); end
    repeat (2) tick();
    exp_bus = {32'h3000_0200, 32'h0000_0013};
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL racc_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
  endtask

  task automatic test_fault;
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    axi.ifu_rresp = 2'b10;
    repeat (2) tick();
    vectors++; if (st !== 4'b1001) begin miscompares++; $display("FAIL fault_set got=%b exp=%b", st, 4'b1001); end
    axi.ifu_rresp = 2'b00;
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL fault_clear got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0208) begin miscompares++; $display("FAIL fault_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0208); end
    repeat (2) tick();
    vectors++; if (st !== 4'b1000) begin miscompares++; $display("FAIL fault_ok got=%b exp=%b", st, 4'b1000); end
  endtask

  task automatic test_misalign;
    exu_dnpc_valid = 1'b1;
    exu_dnpc = 32'h3000_0102;
    tick();
    exu_dnpc_valid = 1'b0;
`ifdef YSYX_25020037_IFU_MISALIGN_CHK_EN
    vectors++; if (st !== 4'b0000) begin miscompares++; $display("FAIL mis_no_ar got=%b exp=%b", st, 4'b0000); end
    tick();
    exp_bus = {32'h3000_0102, 32'h0000_0000};
    vectors++; if (st !== 4'b1001) begin miscompares++; $display("FAIL mis_fault got=%b exp=%b", st, 4'b1001); end
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL mis_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
`else
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL mis_ar got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0102) begin miscompares++; $display("FAIL mis_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0102); end
    repeat (2) tick();
    exp_bus = {32'h3000_0102, 32'h0000_0013};
    vectors++; if (st !== 4'b1000) begin miscompares++; $display("FAIL mis_valid got=%b exp=%b", st, 4'b1000); end
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL mis_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
`endif
  endtask

  task automatic test_wrap;
    exu_dnpc_valid = 1'b1;
    exu_dnpc = 32'hffff_fffc;
    tick();
    exu_dnpc_valid = 1'b0;
    vectors++; if (axi.ifu_araddr !== 32'hffff_fffc) begin miscompares++; $display("FAIL wrap_araddr0 got=%h exp=%h", axi.ifu_araddr, 32'hffff_fffc); end
    repeat (2) tick();
    exp_bus = {32'hffff_fffc, 32'h0000_0013};
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL wrap_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL wrap_status got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_araddr1 got=%h exp=%h", axi.ifu_araddr, 32'h0000_0000); end
  endtask

  task automatic test_redirect_in_ar;
    axi.ifu_arready = 1'b0;
    exu_dnpc_valid = 1'b1;
    exu_dnpc = 32'h3000_1000;
    tick();
    vectors++; if (axi.ifu_araddr !== 32'h0000_0000) begin miscompares++; $display("FAIL ar_hold0 got=%h exp=%h", axi.ifu_araddr, 32'h0000_0000); end
    exu_dnpc = 32'h3000_2000;
    tick();
    exu_dnpc_valid = 1'b0;
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL ar_hold_status got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h0000_0000) begin miscompares++; $display("FAIL ar_hold1 got=%h exp=%h", axi.ifu_araddr, 32'h0000_0000); end
    axi.ifu_arready = 1'b1;
    tick();
    vectors++; if (st !== 4'b0010) begin miscompares++; $display("FAIL ar_to_r got=%b exp=%b", st, 4'b0010); end
    tick();
    vectors++; if (st !== 4'b0100) begin miscompares++; $display("FAIL ar_drop got=%b exp=%b", st, 4'b0100); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_2000) begin miscompares++; $display("FAIL ar_last_wins got=%h exp=%h", axi.ifu_araddr, 32'h3000_2000); end
    repeat (2) tick();
    exp_bus = {32'h3000_2000, 32'h0000_0013};
    vectors++; if (fu_to_du_bus !== exp_bus) begin miscompares++; $display("FAIL ar_bus got=%h exp=%h", fu_to_du_bus, exp_bus); end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1;
    vectors++; if (st !== 4'b0000) begin miscompares++; $display("FAIL arst_status got=%b exp=%b", st, 4'b0000); end
    vectors++; if (axi.ifu_araddr !== 32'h3000_0000) begin miscompares++; $display("FAIL arst_araddr got=%h exp=%h", axi.ifu_araddr, 32'h3000_0000); end
    vectors++; if (fu_to_du_bus !== 64'h0) begin miscompares++; $display("FAIL arst_bus got=%h exp=%h", fu_to_du_bus, 64'h0); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_in_r();
    test_redirect_accept();
    test_fault();
    test_misalign();
    test_wrap();
    test_redirect_in_ar();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
